// File: rtl/store_buffer.sv
// Store buffer: packs SW/SH/SB stores into word-aligned byte-enabled writes and
// queues them in a small FIFO ahead of the data-memory write port.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [1:0]       st_op,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             st_ready,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  output logic             align_err,
  output logic [31:0]      err_addr,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [29:0] wordAddr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } entry_t;

  entry_t             fifoMem [DEPTH];
  entry_t             stEntry;
  entry_t             head;
  logic               stErr;
  logic               stAccept;
  logic               enq;
  logic               deq;
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;

  // Lane packing and alignment check for the presented store
  always_comb begin
    stEntry          = '0;
    stErr            = 1'b0;
    stEntry.wordAddr = st_addr[31:2];
    case (st_op)
      2'b00: begin
        stEntry.be    = 4'b1111;
        stEntry.wdata = st_data;
        stErr         = (st_addr[1:0] != 2'b00);
      end
      2'b01: begin
        stEntry.be    = st_addr[1] ? 4'b1100 : 4'b0011;
        stEntry.wdata = {2{st_data[15:0]}};
        stErr         = st_addr[0];
      end
      2'b10: begin
        stEntry.be    = 4'b0001 << st_addr[1:0];
        stEntry.wdata = {4{st_data[7:0]}};
      end
      default: stErr = 1'b1;
    endcase
  end

  assign st_ready = (count != CNT_W'(DEPTH));
  assign mem_req  = (count != '0);
  assign empty    = (count == '0);
  assign stAccept = st_valid && st_ready;
  assign enq      = stAccept && !stErr;
  assign deq      = mem_req && mem_ack;

  // Occupancy, pointers and error reporting
  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      align_err <= 1'b0;
      err_addr  <= '0;
    end else begin
      align_err <= stAccept && stErr;
      if (stAccept && stErr) err_addr <= st_addr;
      if (enq) wrPtr <= wrPtr + PTR_W'(1);
      if (deq) rdPtr <= rdPtr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity lives in count/pointers
  always_ff @(posedge clk) begin
    if (enq) fifoMem[wrPtr] <= stEntry;
  end

  assign head      = fifoMem[rdPtr];
  assign mem_addr  = mem_req ? {head.wordAddr, 2'b00} : '0;
  assign mem_be    = mem_req ? head.be : '0;
  assign mem_wdata = mem_req ? head.wdata : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: queue-based reference model compared every
// cycle, plus hand-computed literal expectations.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic clk = 1'b0;
  logic reset;
  logic st_valid;
  logic [1:0] st_op;
  logic [31:0] st_addr, st_data;
  logic st_ready, mem_req, mem_ack, align_err, empty;
  logic [31:0] mem_addr, mem_wdata, err_addr;
  logic [3:0] mem_be;
  logic [PTR_W:0] count;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t q[$];
  logic mAlignErr = 1'b0;
  logic [31:0] mErrAddr = '0;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .align_err(align_err),
    .err_addr(err_addr), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a store of N bytes must sit on an N-byte boundary
  always @(posedge clk) begin
    int unsigned size;
    int unsigned pre;
    wr_t w;
    if (!reset) begin
      q.delete();
      mAlignErr = 1'b0;
      mErrAddr  = '0;
    end else begin
      pre = q.size();
      mAlignErr = 1'b0;
      if (pre > 0 && mem_ack) void'(q.pop_front());
      if (st_valid && pre < DEPTH) begin
        size = (st_op == 2'd0) ? 4 : (st_op == 2'd1) ? 2 : 1;
        if (st_op == 2'd3 || (st_addr % size) != 0) begin
          mAlignErr = 1'b1;
          mErrAddr  = st_addr;
        end else begin
          w.addr = st_addr & ~32'd3;
          w.be   = 4'((1 << size) - 1) << st_addr[1:0];
          if (size == 4)      w.data = st_data;
          else if (size == 2) w.data = {2{st_data[15:0]}};
          else                w.data = {4{st_data[7:0]}};
          q.push_back(w);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("mem_req", 32'(mem_req), 32'(q.size() != 0));
      chk("mem_addr", mem_addr, q.size() != 0 ? q[0].addr : 32'd0);
      chk("mem_be", 32'(mem_be), q.size() != 0 ? 32'(q[0].be) : 32'd0);
      chk("mem_wdata", mem_wdata, q.size() != 0 ? q[0].data : 32'd0);
      chk("align_err", 32'(align_err), 32'(mAlignErr));
      chk("err_addr", err_addr, mErrAddr);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #3;
  endtask

  task automatic store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_op = op; st_addr = a; st_data = d;
  endtask

  initial begin
    reset = 1'b0; st_valid = 1'b0; st_op = '0; st_addr = '0; st_data = '0; mem_ack = 1'b0;
    cycle(); cycle();
    reset = 1'b1;
    checking = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);

    // SB to lane 3
    store(2'b10, 32'h1003, 32'h0000_00A5); cycle(); st_valid = 1'b0;
    chk("sb_req", 32'(mem_req), 32'd1);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_be", 32'(mem_be), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    mem_ack = 1'b1; cycle(); mem_ack = 1'b0;
    chk("sb_drained", 32'(empty), 32'd1);

    // SH upper half then SW, head holds without ack
    store(2'b01, 32'h2002, 32'h1234BEEF); cycle();
    store(2'b00, 32'h2004, 32'hCAFEF00D); cycle(); st_valid = 1'b0;
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    cycle();
    chk("sh_hold_be", 32'(mem_be), 32'hC);
    mem_ack = 1'b1; cycle(); mem_ack = 1'b0;
    chk("sw_addr", mem_addr, 32'h2004);
    chk("sw_be", 32'(mem_be), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hCAFEF00D);
    mem_ack = 1'b1; cycle(); mem_ack = 1'b0;

    // Rejected stores: misaligned SW, illegal op, misaligned SH
    store(2'b00, 32'h3001, 32'h1); cycle(); st_valid = 1'b0;
    chk("mis_sw_err", 32'(align_err), 32'd1);
    chk("mis_sw_addr", err_addr, 32'h3001);
    chk("mis_sw_count", 32'(count), 32'd0);
    cycle();
    chk("mis_sw_pulse", 32'(align_err), 32'd0);
    chk("mis_sw_held", err_addr, 32'h3001);
    store(2'b11, 32'h3100, 32'h2); cycle(); st_valid = 1'b0;
    chk("ill_err", 32'(align_err), 32'd1);
    chk("ill_addr", err_addr, 32'h3100);
    cycle();
    store(2'b01, 32'h3003, 32'h3); cycle(); st_valid = 1'b0;
    chk("mis_sh_err", 32'(align_err), 32'd1);
    chk("mis_sh_addr", err_addr, 32'h3003);
    cycle();

    // Fill to full with a fifth store held back, across pointer wrap
    for (int i = 0; i < 5; i++) begin
      store(2'b00, 32'h4000 + 32'(i * 4), 32'h1000 + 32'(i));
      cycle();
      if (i == 3) begin
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(st_ready), 32'd0);
      end
    end
    chk("held_count", 32'(count), 32'd4);
    mem_ack = 1'b1; cycle(); mem_ack = 1'b0;
    chk("ack_ready", 32'(st_ready), 32'd1);
    chk("ack_count", 32'(count), 32'd3);
    chk("ack_head", mem_addr, 32'h4004);
    cycle(); st_valid = 1'b0;
    chk("fifth_in", 32'(count), 32'd4);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    mem_ack = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);

    // Simultaneous enqueue and dequeue at count 2
    store(2'b00, 32'h5000, 32'h50); cycle();
    store(2'b00, 32'h5004, 32'h54); cycle();
    store(2'b00, 32'h5008, 32'h58); mem_ack = 1'b1; cycle();
    st_valid = 1'b0; mem_ack = 1'b0;
    chk("sim_count", 32'(count), 32'd2);
    chk("sim_head", mem_addr, 32'h5004);
    mem_ack = 1'b1; cycle(); cycle(); mem_ack = 1'b0;

    // Reset mid-handshake with a store pending
    store(2'b00, 32'h6000, 32'h60); cycle();
    store(2'b00, 32'h6004, 32'h64); cycle();
    store(2'b00, 32'h6008, 32'h68); cycle();
    chk("pre_rst_count", 32'(count), 32'd3);
    store(2'b00, 32'h600C, 32'h6C); mem_ack = 1'b1; reset = 1'b0; cycle();
    reset = 1'b1; st_valid = 1'b0; mem_ack = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_err", 32'(align_err), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    store(2'b10, 32'h6001, 32'h0000_0077); cycle(); st_valid = 1'b0;
    chk("post_rst_be", 32'(mem_be), 32'h2);
    chk("post_rst_wdata", mem_wdata, 32'h77777777);
    chk("post_rst_count", 32'(count), 32'd1);
    mem_ack = 1'b1; cycle(); mem_ack = 1'b0;
    cycle();

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
